// File: rtl/imem_word_loader.sv
// rtl/imem_word_loader.sv - packs UART loader bytes into 32-bit words and writes them to instruction memory
module imem_word_loader #(
    parameter int          ADDR_W  = 6,
    parameter logic [23:0] IDLE_TO = 24'd12_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [7:0]        byte_i,
    input  logic              byte_wr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              load_done,
    output logic              overflow,
    output logic              frag_err,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT, S_DONE} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    logic                r_byte_wr_q;
    logic                r_load_en_q;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_asm;
    logic [23:0]         r_timer;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_word_cnt;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_load_done;
    logic                r_overflow;
    logic                r_frag_err;
    logic                r_busy;

    logic w_byte_edge;
    logic w_full;

    assign w_byte_edge = byte_wr & ~r_byte_wr_q;
    assign w_full      = (r_word_cnt == FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_wr_q  <= 1'b0;
            r_load_en_q  <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_timer      <= 24'd0;
            r_wr_ptr     <= '0;
            r_word_cnt   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
            r_frag_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_byte_wr_q <= byte_wr;
            r_load_en_q <= load_en;
            r_imem_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        r_state <= S_COLLECT;
                        r_busy  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    // load_en dropping wins over a coincident byte edge
                    if (!load_en) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_load_done <= 1'b1;
                        r_frag_err  <= (r_byte_idx != 2'd0);
                        r_byte_idx  <= 2'd0;
                        r_timer     <= 24'd0;
                    end else if (w_byte_edge) begin
                        r_timer <= 24'd0;
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            case (r_byte_idx)
                                2'd0: r_asm[7:0]   <= byte_i;
                                2'd1: r_asm[15:8]  <= byte_i;
                                2'd2: r_asm[23:16] <= byte_i;
                                default: begin
                                    r_imem_wdata <= {byte_i, r_asm};
                                    r_imem_addr  <= r_wr_ptr;
                                    r_imem_we    <= 1'b1;
                                    r_state      <= S_COMMIT;
                                end
                            endcase
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end else if (r_timer == IDLE_TO) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_load_done <= 1'b1;
                        r_timer     <= 24'd0;
                    end else if (r_word_cnt != '0 && r_byte_idx == 2'd0) begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_COMMIT: begin
                    r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                    r_word_cnt <= r_word_cnt + (ADDR_W+1)'(1);
                    r_state    <= S_COLLECT;
                    // the commit cycle already counts toward the idle timeout
                    if (w_byte_edge) begin
                        r_asm[7:0] <= byte_i;
                        r_byte_idx <= 2'd1;
                        r_timer    <= 24'd0;
                    end else begin
                        r_timer <= 24'd1;
                    end
                end
                S_DONE: begin
                    if (load_en && !r_load_en_q) begin
                        r_state     <= S_COLLECT;
                        r_busy      <= 1'b1;
                        r_wr_ptr    <= '0;
                        r_word_cnt  <= '0;
                        r_byte_idx  <= 2'd0;
                        r_timer     <= 24'd0;
                        r_load_done <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_frag_err  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign word_cnt   = r_word_cnt;
    assign load_done  = r_load_done;
    assign overflow   = r_overflow;
    assign frag_err   = r_frag_err;
    assign busy       = r_busy;

endmodule
